// File: rtl/key_repeat_if.sv
// key_repeat_if: keycode in, latched move command out, between keyboard and game logic.
interface key_repeat_if;
  logic [7:0] keycode;
  logic       move_tick;
  logic [7:0] cmd_code;
  logic       cmd_valid;
  logic       press_pulse;
  modport master (output keycode, move_tick, input cmd_code, cmd_valid, press_pulse);
  modport slave  (input keycode, move_tick, output cmd_code, cmd_valid, press_pulse);
endinterface

// File: rtl/key_repeat_ctrl.sv
// key_repeat_ctrl: turns a held keycode into press + delayed auto-repeat commands,
// latched until game logic consumes them on its move tick.
module key_repeat_ctrl #(
  parameter int DAS_FRAMES = 10,
  parameter int ARR_FRAMES = 3,
  parameter bit ROT_REPEAT = 1'b0
) (
  input  logic         frame_clk,
  input  logic         Reset,
  key_repeat_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_e;
  localparam logic [5:0] DAS_LAST = 6'(DAS_FRAMES - 1);
  localparam logic [5:0] ARR_LAST = 6'(ARR_FRAMES - 1);
  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [7:0] prev_q, code_q, code_d, key;
  logic       valid_q, valid_d, pulse_q, pulse_d, fire, press, held, rot_hold;
  always_comb begin
    key = (bus.keycode == 8'h04 || bus.keycode == 8'h07 ||
           bus.keycode == 8'h16 || bus.keycode == 8'h1A) ? bus.keycode : 8'h00;
    press = key != 8'h00 && key != prev_q;
    held = key != 8'h00 && key == prev_q;
    rot_hold = key == 8'h1A && !ROT_REPEAT;
    state_d = state_q;
    cnt_d = cnt_q;
    fire = 1'b0;
    pulse_d = 1'b0;
    if (press) begin
      fire = 1'b1;
      pulse_d = 1'b1;
      cnt_d = '0;
      state_d = DELAY;
    end else if (!held) begin
      cnt_d = '0;
      state_d = IDLE;
    end else if (state_q == DELAY && rot_hold) begin
      cnt_d = (cnt_q == DAS_LAST) ? cnt_q : cnt_q + 6'd1;
    end else if (state_q == DELAY) begin
      fire = cnt_q == DAS_LAST;
      cnt_d = fire ? 6'd0 : cnt_q + 6'd1;
      state_d = fire ? REPEAT : DELAY;
    end else if (state_q == REPEAT) begin
      fire = cnt_q == ARR_LAST;
      cnt_d = fire ? 6'd0 : cnt_q + 6'd1;
    end
    // a fire on the consume edge wins, so a fresh command is never dropped
    code_d = fire ? key : (bus.move_tick ? 8'h00 : code_q);
    valid_d = fire | (valid_q & ~bus.move_tick);
  end
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      prev_q <= 8'h00;
      code_q <= 8'h00;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      prev_q <= key;
      code_q <= code_d;
      valid_q <= valid_d;
      pulse_q <= pulse_d;
    end
  end
  assign bus.cmd_code = code_q;
  assign bus.cmd_valid = valid_q;
  assign bus.press_pulse = pulse_q;
endmodule

// File: tb/tb_key_repeat_ctrl.sv
// tb_key_repeat_ctrl: directed and random key sequences checked against a
// hold-duration model of press / delayed auto-shift / repeat behaviour.
module tb_key_repeat_ctrl;
  localparam int DAS = 10;
  localparam int ARR = 3;
  localparam bit ROT = 1'b0;
  logic frame_clk = 1'b0;
  logic Reset = 1'b1;
  int checks = 0;
  int failures = 0;
  key_repeat_if bus();
  key_repeat_ctrl #(.DAS_FRAMES(DAS), .ARR_FRAMES(ARR), .ROT_REPEAT(ROT)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .bus(bus.slave));
  always #5 frame_clk = ~frame_clk;
  logic [7:0] m_prev = 8'h00, m_code = 8'h00;
  logic m_valid = 1'b0, m_pulse = 1'b0;
  int m_k = 0;
  string tag = "reset";
  function automatic logic [7:0] filt(input logic [7:0] k);
    return (k == 8'h04 || k == 8'h07 || k == 8'h16 || k == 8'h1A) ? k : 8'h00;
  endfunction
  task automatic model_reset();
    m_prev = 8'h00; m_code = 8'h00; m_valid = 1'b0; m_pulse = 1'b0; m_k = 0;
  endtask
  // fires happen at hold age 0, DAS, DAS+ARR, DAS+2*ARR ... counted in frames since press
  task automatic model(input logic [7:0] k, input logic t);
    logic [7:0] f;
    logic fire;
    f = filt(k);
    fire = 1'b0;
    m_pulse = 1'b0;
    if (f != 8'h00 && f != m_prev) begin
      m_k = 0; fire = 1'b1; m_pulse = 1'b1;
    end else if (f != 8'h00) begin
      m_k++;
      if (!(f == 8'h1A && !ROT) && (m_k == DAS || (m_k > DAS && (m_k - DAS) % ARR == 0)))
        fire = 1'b1;
    end
    m_prev = f;
    if (fire) begin m_code = f; m_valid = 1'b1; end
    else if (t) begin m_code = 8'h00; m_valid = 1'b0; end
  endtask
  task automatic check();
    checks++;
    assert (bus.cmd_code === m_code) else begin
      failures++;
      $error("FAIL %s cmd_code got=%h exp=%h t=%0t", tag, bus.cmd_code, m_code, $time);
    end
    checks++;
    assert (bus.cmd_valid === m_valid) else begin
      failures++;
      $error("FAIL %s cmd_valid got=%b exp=%b t=%0t", tag, bus.cmd_valid, m_valid, $time);
    end
    checks++;
    assert (bus.press_pulse === m_pulse) else begin
      failures++;
      $error("FAIL %s press_pulse got=%b exp=%b t=%0t", tag, bus.press_pulse, m_pulse, $time);
    end
  endtask
  task automatic step(input logic [7:0] k, input logic t);
    bus.keycode = k;
    bus.move_tick = t;
    @(posedge frame_clk);
    model(k, t);
    #1 check();
  endtask
  task automatic hold(input logic [7:0] k, input int n, input logic t);
    for (int i = 0; i < n; i++) step(k, t);
  endtask
  initial begin
    logic [7:0] keys [6];
    keys = '{8'h00, 8'h04, 8'h07, 8'h16, 8'h1A, 8'h55};
    bus.keycode = 8'h00;
    bus.move_tick = 1'b0;
    #12 check();
    @(negedge frame_clk) Reset = 1'b0;
    tag = "tap04";
    step(8'h04, 1'b0);
    hold(8'h00, 4, 1'b0);
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    tag = "hold07";
    hold(8'h07, 20, 1'b1);
    hold(8'h00, 2, 1'b1);
    tag = "rot1A";
    hold(8'h1A, 30, 1'b1);
    hold(8'h00, 2, 1'b0);
    tag = "switch04_16";
    hold(8'h04, 4, 1'b0);
    hold(8'h16, 9, 1'b0);
    step(8'h16, 1'b1);
    step(8'h16, 1'b0);
    tag = "latest_wins";
    step(8'h00, 1'b1);
    step(8'h04, 1'b0);
    step(8'h07, 1'b0);
    step(8'h07, 1'b1);
    tag = "invalid55";
    hold(8'h55, 15, 1'b0);
    step(8'h55, 1'b1);
    tag = "rst_mid_delay";
    hold(8'h04, 5, 1'b0);
    #2 Reset = 1'b1;
    #1 model_reset();
    check();
    @(negedge frame_clk) Reset = 1'b0;
    step(8'h04, 1'b0);
    hold(8'h04, 12, 1'b0);
    tag = "random";
    for (int r = 0; r < 60; r++) begin
      logic [7:0] k;
      int n;
      k = keys[$urandom_range(0, 5)];
      n = $urandom_range(1, 25);
      for (int i = 0; i < n; i++) step(k, 1'($urandom_range(0, 2) == 0));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
